// File: rtl/prng_range.sv
// Maps raw PRNG samples (1..m-1) onto a uniform range 0..n-1 using rejection
// sampling against lim=(m-1)-((m-1) mod n), with one shared serial divider.
module prng_range (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg,
    input  logic [31:0] m,
    input  logic [31:0] n,
    output logic        prng_start,
    output logic        prng_cont,
    input  logic        prng_done,
    input  logic [31:0] prng_rand,
    output logic        valid,
    input  logic        ready,
    output logic [31:0] value,
    output logic [15:0] rej_cnt,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_LIM, S_WAIT, S_DIV, S_OUT} state_t;

    state_t      state_q, state_d;
    logic [31:0] m_q, m_d;
    logic [31:0] n_q, n_d;
    logic [31:0] lim_q, lim_d;
    logic [31:0] quo_q, quo_d;
    logic [32:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        start_q, start_d;
    logic        cont_q, cont_d;
    logic        valid_q, valid_d;
    logic [31:0] value_q, value_d;
    logic [15:0] rej_q, rej_d;
    logic        err_q, err_d;

    // One restoring-divider step; the shifted partial remainder is kept wide
    // enough that the compare/subtract never overflows for any 32-bit n.
    logic [33:0] rem_sh;
    logic        ge;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] rand_m1;
    logic        rand_bad;

    always_comb begin
        rem_sh   = {rem_q, quo_q[31]};
        ge       = (rem_sh >= {2'b00, n_q});
        rem_nx   = ge ? (rem_sh[32:0] - {1'b0, n_q}) : rem_sh[32:0];
        quo_nx   = {quo_q[30:0], ge};
        rand_m1  = prng_rand - 32'd1;
        rand_bad = (prng_rand == 32'd0) || (prng_rand >= m_q);
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        lim_d   = lim_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        cont_d  = 1'b0;
        valid_d = valid_q;
        value_d = value_q;
        rej_d   = rej_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cfg) begin
                    m_d   = m;
                    n_d   = n;
                    rej_d = '0;
                    err_d = 1'b0;
                    if (n == 32'd0 || n > m - 32'd1) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_LIM;
                        quo_d   = m - 32'd1;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            S_LIM: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    lim_d   = (m_q - 32'd1) - rem_nx[31:0];
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (prng_done) begin
                    start_d = 1'b0;
                    if (rand_bad || rand_m1 >= lim_q) begin
                        if (rand_bad) err_d = 1'b1;
                        if (rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
                        cont_d = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        quo_d   = rand_m1;
                        rem_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            S_DIV: begin
                quo_d = quo_nx;
                rem_d = rem_nx;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    value_d = rem_nx[31:0];
                    valid_d = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (ready) begin
                    valid_d = 1'b0;
                    cont_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            lim_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            cont_q  <= 1'b0;
            valid_q <= 1'b0;
            value_q <= '0;
            rej_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            lim_q   <= lim_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            cont_q  <= cont_d;
            valid_q <= valid_d;
            value_q <= value_d;
            rej_q   <= rej_d;
            err_q   <= err_d;
        end
    end

    assign prng_start = start_q;
    assign prng_cont  = cont_q;
    assign valid      = valid_q;
    assign value      = value_q;
    assign rej_cnt    = rej_q;
    assign err        = err_q;

endmodule

// File: tb/tb_prng_range.sv
// Directed bench for prng_range: drives a fake upstream PRNG and a consumer,
// checks against hand-computed values.
module tb_prng_range;

    logic        clk = 1'b0;
    logic        rst, cfg, prng_done, ready;
    logic [31:0] m, n, prng_rand;
    logic        prng_start, prng_cont, valid, err;
    logic [31:0] value;
    logic [15:0] rej_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [31:0] M31 = 32'd2147483647;

    prng_range dut (
        .clk(clk), .rst(rst), .cfg(cfg), .m(m), .n(n),
        .prng_start(prng_start), .prng_cont(prng_cont),
        .prng_done(prng_done), .prng_rand(prng_rand),
        .valid(valid), .ready(ready), .value(value),
        .rej_cnt(rej_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg = 1'b0; prng_done = 1'b0; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_cfg(input logic [31:0] mm, input logic [31:0] nn);
        cfg = 1'b1; m = mm; n = nn;
        tick();
        cfg = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!prng_start && cyc < 100) begin tick(); cyc++; end
    endtask

    // Pulses prng_done with the given sample and counts edges until valid.
    task automatic feed_until_valid(input logic [31:0] r, output int cyc);
        prng_done = 1'b1; prng_rand = r;
        tick();
        prng_done = 1'b0;
        cyc = 1;
        while (!valid && cyc < 100) begin tick(); cyc++; end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({valid, prng_start, prng_cont, err} !== 4'b0 || value !== 32'd0 || rej_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b s=%b c=%b e=%b val=%0d rej=%0d, want all 0",
                     valid, prng_start, prng_cont, err, value, rej_cnt);
        end
    endtask

    task automatic test_basic();
        int cyc;
        do_cfg(M31, 32'd6);
        wait_start(cyc);
        tests_run++;
        if (cyc !== 32) begin tests_failed++; $display("FAIL lim_latency: got %0d want 32", cyc); end
        tick();
        tests_run++;
        if (prng_start !== 1'b1) begin tests_failed++; $display("FAIL start_held: got %b want 1", prng_start); end
        feed_until_valid(32'd1000, cyc);
        tests_run++;
        if (cyc !== 33) begin tests_failed++; $display("FAIL div_latency: got %0d want 33", cyc); end
        tests_run++;
        if (value !== 32'd3) begin tests_failed++; $display("FAIL basic_value: got %0d want 3", value); end
        tests_run++;
        if (prng_start !== 1'b0) begin tests_failed++; $display("FAIL start_dropped: got %b want 0", prng_start); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tests_run++;
        if (valid !== 1'b0 || prng_cont !== 1'b1) begin
            tests_failed++; $display("FAIL basic_handshake: got v=%b c=%b want v=0 c=1", valid, prng_cont);
        end
        tick();
        tests_run++;
        if (prng_cont !== 1'b0) begin tests_failed++; $display("FAIL basic_cont_pulse: got %b want 0", prng_cont); end
    endtask

    task automatic test_reject();
        int cyc;
        do_reset();
        do_cfg(M31, 32'd1000000);
        wait_start(cyc);
        prng_done = 1'b1; prng_rand = 32'd2147000001;
        tick();
        prng_done = 1'b0;
        tests_run++;
        if (rej_cnt !== 16'd1 || prng_cont !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_lim: got rej=%0d c=%b e=%b want rej=1 c=1 e=0", rej_cnt, prng_cont, err);
        end
        tick();
        tests_run++;
        if (prng_cont !== 1'b0 || prng_start !== 1'b0 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reject_after: got c=%b s=%b v=%b want 0 0 0", prng_cont, prng_start, valid);
        end
        feed_until_valid(32'd12345679, cyc);
        tests_run++;
        if (value !== 32'd345678 || cyc !== 33) begin
            tests_failed++; $display("FAIL reject_then_accept: got %0d (cyc %0d) want 345678 (33)", value, cyc);
        end
        ready = 1'b1; tick(); ready = 1'b0; tick();
        // r' = lim-1 is the largest sample that must be accepted
        feed_until_valid(32'd2147000000, cyc);
        tests_run++;
        if (value !== 32'd999999 || rej_cnt !== 16'd1) begin
            tests_failed++; $display("FAIL lim_edge_accept: got %0d rej=%0d want 999999 rej=1", value, rej_cnt);
        end
        ready = 1'b1; tick(); ready = 1'b0;
    endtask

    task automatic test_cfg_err();
        bit saw_start;
        int cyc;
        do_reset();
        do_cfg(M31, 32'd0);
        saw_start = 1'b0;
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL cfg_n0_err: got %b want 1", err); end
        repeat (40) begin tick(); if (prng_start) saw_start = 1'b1; end
        do_cfg(M31, M31);
        tests_run++;
        if (err !== 1'b1) begin tests_failed++; $display("FAIL cfg_nbig_err: got %b want 1", err); end
        repeat (40) begin tick(); if (prng_start) saw_start = 1'b1; end
        tests_run++;
        if (saw_start !== 1'b0) begin tests_failed++; $display("FAIL cfg_err_start: got %b want 0", saw_start); end
        // still IDLE: n=m-1 is the largest legal range and must be accepted
        do_cfg(M31, M31 - 32'd1);
        tests_run++;
        if (err !== 1'b0) begin tests_failed++; $display("FAIL cfg_err_cleared: got %b want 0", err); end
        wait_start(cyc);
        tests_run++;
        if (cyc !== 32) begin tests_failed++; $display("FAIL cfg_nmax_start: got %0d want 32", cyc); end
    endtask

    task automatic test_backpressure();
        int cyc;
        bit bad;
        do_reset();
        do_cfg(M31, 32'd6);
        wait_start(cyc);
        feed_until_valid(32'd1000, cyc);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin cfg = 1'b1; m = M31; n = 32'd0; end
            tick();
            cfg = 1'b0;
            if (valid !== 1'b1 || value !== 32'd3 || prng_cont !== 1'b0 || err !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL backpressure_hold: got v=%b val=%0d c=%b e=%b want 1 3 0 0", valid, value, prng_cont, err);
        end
        ready = 1'b1; tick(); ready = 1'b0;
        tests_run++;
        if (prng_cont !== 1'b1 || valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_handshake: got c=%b v=%b want 1 0", prng_cont, valid);
        end
        tick();
        tests_run++;
        if (prng_cont !== 1'b0) begin tests_failed++; $display("FAIL bp_single_cont: got %b want 0", prng_cont); end
    endtask

    task automatic test_rst_mid_div();
        int cyc;
        bit saw;
        do_reset();
        do_cfg(M31, 32'd6);
        wait_start(cyc);
        prng_done = 1'b1; prng_rand = 32'd1000;
        tick();
        prng_done = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({valid, prng_start, prng_cont, err} !== 4'b0 || value !== 32'd0 || rej_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_div: got v=%b s=%b c=%b e=%b val=%0d rej=%0d want 0",
                     valid, prng_start, prng_cont, err, value, rej_cnt);
        end
        saw = 1'b0;
        repeat (40) begin tick(); if (valid || prng_start) saw = 1'b1; end
        tests_run++;
        if (saw !== 1'b0) begin tests_failed++; $display("FAIL rst_no_partial: got %b want 0", saw); end
        do_cfg(M31, 32'd6);
        wait_start(cyc);
        feed_until_valid(32'd1000, cyc);
        tests_run++;
        if (value !== 32'd3 || cyc !== 33) begin
            tests_failed++; $display("FAIL rst_rerun: got %0d (cyc %0d) want 3 (33)", value, cyc);
        end
        ready = 1'b1; tick(); ready = 1'b0;
    endtask

    task automatic test_bad_rand();
        int cyc;
        bit saw;
        do_reset();
        do_cfg(M31, 32'd6);
        wait_start(cyc);
        prng_done = 1'b1; prng_rand = 32'd0;
        tick();
        prng_done = 1'b0;
        tests_run++;
        if (err !== 1'b1 || rej_cnt !== 16'd1 || prng_cont !== 1'b1 || valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rand_zero: got e=%b rej=%0d c=%b v=%b want 1 1 1 0", err, rej_cnt, prng_cont, valid);
        end
        tick();
        prng_done = 1'b1; prng_rand = M31;
        tick();
        prng_done = 1'b0;
        tests_run++;
        if (rej_cnt !== 16'd2 || prng_cont !== 1'b1) begin
            tests_failed++; $display("FAIL rand_eq_m: got rej=%0d c=%b want 2 1", rej_cnt, prng_cont);
        end
        saw = 1'b0;
        repeat (40) begin tick(); if (valid) saw = 1'b1; end
        tests_run++;
        if (saw !== 1'b0 || err !== 1'b1) begin
            tests_failed++; $display("FAIL rand_bad_novalid: got v=%b e=%b want 0 1", saw, err);
        end
    endtask

    initial begin
        rst = 1'b1; cfg = 1'b0; prng_done = 1'b0; ready = 1'b0;
        m = '0; n = '0; prng_rand = '0;
        test_reset();
        test_basic();
        test_reject();
        test_cfg_err();
        test_backpressure();
        test_rst_mid_div();
        test_bad_rand();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prng_range.md
PRNG_RANGE -- requirements
Module: prng_range

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have cfg, input, 1, one-cycle pulse; loads m and n and starts operation; honoured only in IDLE.
REQ-004 SHALL have m, input, 32, upstream PRNG modulus, sampled on an accepted cfg.
REQ-005 SHALL have n, input, 32, output range size, sampled on an accepted cfg.
REQ-006 SHALL have prng_start, output, 1, start request to the upstream PRNG.
REQ-007 SHALL have prng_cont, output, 1, one-cycle request for the next PRNG value.
REQ-008 SHALL have prng_done, input, 1, one-cycle pulse qualifying prng_rand.
REQ-009 SHALL have prng_rand, input, 32, PRNG value, legal range 1..m-1.
REQ-010 SHALL have valid, output, 1, value holds a result.
REQ-011 SHALL have ready, input, 1, consumer accepts value when valid && ready.
REQ-012 SHALL have value, output, 32, uniform result in 0..n-1.
REQ-013 SHALL have rej_cnt, output, 16, saturating count of rejected samples since the last cfg.
REQ-014 SHALL have err, output, 1, sticky error flag, cleared only by rst or an accepted cfg.

Function
REQ-015 SHALL implement the states IDLE, LIM, WAIT, DIV and OUT.
REQ-016 On cfg in IDLE, SHALL latch m and n, clear rej_cnt and err, and go to LIM.
REQ-017 If n==0 or n>m-1 at cfg, SHALL set err and stay in IDLE; prng_start SHALL stay low.
REQ-018 LIM SHALL compute rem=(m-1) mod n with a 32-iteration restoring divider (exactly 32 cycles), set lim=(m-1)-rem, then go to WAIT.
REQ-019 prng_start SHALL go high on entry to the first WAIT after cfg and stay high until the first prng_done; it SHALL be low at all other times.
REQ-020 In WAIT, a prng_done pulse SHALL sample r'=prng_rand-1; prng_done outside WAIT SHALL be ignored.
REQ-021 If prng_rand==0 or prng_rand>=m, SHALL set err, treat the sample as rejected, and apply REQ-022.
REQ-022 If r'>=lim, SHALL reject the sample: increment rej_cnt (saturating at 0xFFFF), pulse prng_cont the next cycle, and stay in WAIT.
REQ-023 If r'<lim, SHALL go to DIV and compute r' mod n in exactly 32 cycles.
REQ-024 SHALL assert valid 33 cycles after the accepting prng_done cycle; value = r' mod n.
REQ-025 In OUT, value and valid SHALL hold stable until valid && ready.
REQ-026 On the handshake cycle, SHALL drop valid the next cycle, pulse prng_cont for one cycle, and return to WAIT.
REQ-027 SHALL not assert prng_cont while valid is high; at most one PRNG request SHALL be outstanding.
REQ-028 cfg outside IDLE SHALL be ignored; only rst returns the block to IDLE.
REQ-029 All arithmetic SHALL be unsigned 32-bit; the divider SHALL use a 33-bit partial remainder so no overflow occurs for any legal m and n.

Reset
REQ-030 rst SHALL force IDLE, and clear valid, value, prng_start, prng_cont, rej_cnt, err, lim and the divider registers.
REQ-031 rst SHALL take effect from any state, including mid-LIM and mid-DIV; no partial result SHALL appear afterwards.

Verification
REQ-032 m=2147483647, n=6, cfg; after prng_start, drive prng_done with prng_rand=1000 -> lim=2147483646, valid 33 cycles later, value=3.
REQ-033 m=2147483647, n=1000000 -> lim=2147000000; prng_rand=2147000001 -> rejected, rej_cnt=1, one prng_cont pulse; then prng_rand=12345679 -> value=345678.
REQ-034 cfg with n=0, and separately with n=2147483647 and m=2147483647 -> err=1, state IDLE, prng_start never asserted.
REQ-035 ready held low 10 cycles with valid=1 -> value stable and no prng_cont; ready=1 -> exactly one prng_cont pulse one cycle after the handshake.
REQ-036 rst asserted at DIV cycle 15 -> next cycle all outputs are 0; a new cfg is accepted and repeating REQ-032 gives value=3.
REQ-037 prng_rand=0 in WAIT -> err=1, rej_cnt increments, prng_cont pulses, no valid.
